// File: rtl/hpdl_pkg.sv
// Shared types and constants for the HPDL1414 refresh controller.
// Holds the FSM encoding and the character filter.
package hpdl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_NEXT
  } state_e;

  localparam int         NUM_CHARS  = 16;
  localparam logic [7:0] CHAR_MIN   = 8'h20;
  localparam logic [7:0] CHAR_MAX   = 8'h5F;
  localparam logic [7:0] CHAR_BLANK = 8'h20;

  // Bytes outside the displayable range are shown as a blank.
  function automatic logic [6:0] char_filter(input logic [7:0] b);
    logic [6:0] r;
    r = CHAR_BLANK[6:0];
    if (b >= CHAR_MIN && b <= CHAR_MAX)
      r = b[6:0];
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
// Counts 0..DIV-1 and wraps; ticks on the last count.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int         W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign o_tick = (cnt_q == LAST);
  assign cnt_d  = o_tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_refresh_ctrl.sv
// Refreshes four HPDL1414 chips (16 chars) from a small buffer,
// one character per WR cycle, plus a caret blink strobe.
module display_refresh_ctrl
  import hpdl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter int WR_SETUP    = 2,
  parameter int WR_PULSE    = 4,
  parameter int WR_HOLD     = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  output logic       o_mem_read_enable,
  output logic [3:0] o_mem_read_address,
  input  logic [7:0] i_mem_read_data,
  output logic       o_caret_strobe,
  output logic [6:0] o_disp_data,
  output logic [1:0] o_disp_addr,
  output logic [3:0] o_disp_wr_n,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int PMAX_A = (WR_SETUP > WR_PULSE) ? WR_SETUP : WR_PULSE;
  localparam int PMAX   = (PMAX_A > WR_HOLD) ? PMAX_A : WR_HOLD;
  localparam int PW     = $clog2(PMAX + 1);

  localparam logic [PW-1:0] LD_SETUP = PW'(WR_SETUP - 1);
  localparam logic [PW-1:0] LD_PULSE = PW'(WR_PULSE - 1);
  localparam logic [PW-1:0] LD_HOLD  = PW'(WR_HOLD - 1);
  localparam logic [3:0]    LAST_IDX = 4'(NUM_CHARS - 1);

  logic ref_tick;
  logic blink_tick;

  tick_gen #(.DIV(REFRESH_DIV)) u_ref (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (ref_tick)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (blink_tick)
  );

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [6:0]    data_q, data_d;
  logic [1:0]    addr_q, addr_d;
  logic [1:0]    chip_q, chip_d;
  logic          caret_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ph_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      chip_q  <= '0;
      caret_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      chip_q  <= chip_d;
      if (blink_tick) caret_q <= ~caret_q;
    end
  end

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    ph_d              = ph_q;
    data_d            = data_q;
    addr_d            = addr_q;
    chip_d            = chip_q;
    o_mem_read_enable = 1'b0;
    o_disp_wr_n       = 4'hF;
    o_busy            = (state_q != S_IDLE);
    o_frame_done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ref_tick && i_enable) begin
          idx_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        o_mem_read_enable = 1'b1;
        state_d           = S_LATCH;
      end
      S_LATCH: begin
        data_d  = char_filter(i_mem_read_data);
        addr_d  = ~idx_q[1:0];
        chip_d  = idx_q[3:2];
        ph_d    = LD_SETUP;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        if (ph_q == '0) begin
          ph_d    = LD_PULSE;
          state_d = S_PULSE;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      S_PULSE: begin
        o_disp_wr_n[chip_q] = 1'b0;
        if (ph_q == '0) begin
          ph_d    = LD_HOLD;
          state_d = S_HOLD;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (ph_q == '0) state_d = S_NEXT;
        else            ph_d    = ph_q - 1'b1;
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          o_frame_done = 1'b1;
          o_busy       = 1'b0;
          state_d      = S_IDLE;
        end else if (i_enable) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end else begin
          o_busy  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_mem_read_address = idx_q;
  assign o_disp_data        = data_q;
  assign o_disp_addr        = addr_q;
  assign o_caret_strobe     = caret_q;

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Bench for display_refresh_ctrl: buffer model, write monitor,
// and an expected-frame model built from the character rules.
module tb_display_refresh_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       rden;
  logic [3:0] raddr;
  logic [7:0] rdata;
  logic       caret;
  logic [6:0] ddata;
  logic [1:0] daddr;
  logic [3:0] wr_n;
  logic       busy;
  logic       fd;

  display_refresh_ctrl #(
    .REFRESH_DIV (200),
    .BLINK_DIV   (10),
    .WR_SETUP    (2),
    .WR_PULSE    (4),
    .WR_HOLD     (2)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_enable           (en),
    .o_mem_read_enable  (rden),
    .o_mem_read_address (raddr),
    .i_mem_read_data    (rdata),
    .o_caret_strobe     (caret),
    .o_disp_data        (ddata),
    .o_disp_addr        (daddr),
    .o_disp_wr_n        (wr_n),
    .o_busy             (busy),
    .o_frame_done       (fd)
  );

  typedef struct {
    int chip;
    int addr;
    int data;
    int len;
    bit su;
    bit ho;
  } wr_t;

  logic [7:0] mem [16];
  wr_t        wq [$];
  wr_t        cur;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int scnt   = 0;
  int fd_cnt = 0;
  int fd_scnt, fd_busy;
  int rd_cnt = 0;
  int rd_bad = 0;
  int rd0_scnt, rd0_busy;
  int bad_wr = 0;
  int rise_scnt, busy_fall;
  int n_edge = 0;
  int edge_c [3];
  bit in_low   = 0;
  bit hold_pend = 0;
  logic [3:0] pw = 4'hF;
  logic       pb = 1'b0;
  logic       pc = 1'b1;
  logic [6:0] h1d, h2d;
  logic [1:0] h1a, h2a;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_char(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h5F) return int'(b) & 8'h7F;
    return 8'h20;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Buffer: data valid one cycle after the read strobe
  initial begin
    rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (rden) rdata <= mem[raddr];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) cyc++;
    end
  end

  // Write monitor
  initial begin
    forever begin
      @(negedge clk);
      scnt++;
      if (rst) begin
        in_low    = 0;
        hold_pend = 0;
        pw        = 4'hF;
        pb        = 1'b0;
        pc        = 1'b1;
      end else begin
        if ($countones(~wr_n) > 1) bad_wr++;
        if (rden) begin
          rd_cnt++;
          if (!busy) rd_bad++;
          if (raddr == 4'd0) begin
            rd0_scnt = scnt;
            rd0_busy = int'(busy);
          end
        end
        if (fd) begin
          fd_cnt++;
          fd_scnt = scnt;
          fd_busy = int'(busy);
        end
        if (pb && !busy) busy_fall = scnt;
        if (wr_n != 4'hF) begin
          if (pw == 4'hF) begin
            in_low = 1;
            for (int k = 0; k < 4; k++)
              if (!wr_n[k]) cur.chip = k;
            cur.addr = int'(daddr);
            cur.data = int'(ddata);
            cur.len  = 1;
            cur.su   = (h1d == ddata) && (h2d == ddata) &&
                       (h1a == daddr) && (h2a == daddr);
            cur.ho   = 1;
          end else begin
            cur.len++;
            if (int'(ddata) != cur.data || int'(daddr) != cur.addr)
              cur.su = 0;
          end
        end else if (pw != 4'hF) begin
          in_low    = 0;
          rise_scnt = scnt;
          hold_pend = 1;
          cur.ho    = (int'(ddata) == cur.data) && (int'(daddr) == cur.addr);
        end else if (hold_pend) begin
          hold_pend = 0;
          cur.ho    = cur.ho && (int'(ddata) == cur.data) &&
                      (int'(daddr) == cur.addr);
          wq.push_back(cur);
        end
        if (caret != pc && n_edge < 3) begin
          edge_c[n_edge] = cyc;
          n_edge++;
        end
        pc = caret;
        pw = wr_n;
        pb = busy;
      end
      h2d = h1d;
      h1d = ddata;
      h2a = h1a;
      h1a = daddr;
    end
  end

  task automatic wait_fd(input string nm, input int base);
    int n;
    n = 0;
    while (fd_cnt == base && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_fd_seen"}, int'(fd_cnt != base), 1);
  endtask

  task automatic check_frame(input string nm);
    chk({nm, "_nwr"}, wq.size(), 16);
    for (int i = 0; i < 16 && i < wq.size(); i++) begin
      chk($sformatf("%s_chip%0d", nm, i), wq[i].chip, i / 4);
      chk($sformatf("%s_addr%0d", nm, i), wq[i].addr, 3 - (i % 4));
      chk($sformatf("%s_data%0d", nm, i), wq[i].data, exp_char(mem[i]));
      chk($sformatf("%s_wrlen%0d", nm, i), wq[i].len, 4);
      chk($sformatf("%s_setup%0d", nm, i), int'(wq[i].su), 1);
      chk($sformatf("%s_hold%0d", nm, i), int'(wq[i].ho), 1);
    end
  endtask

  task automatic run_frame(input string nm);
    int base;
    wq.delete();
    base = fd_cnt;
    wait_fd(nm, base);
    repeat (5) @(posedge clk);
    check_frame(nm);
    chk({nm, "_fd_pulses"}, fd_cnt - base, 1);
    chk({nm, "_latency"}, fd_scnt - rd0_scnt + 1, 176);
    chk({nm, "_busy_at_read"}, rd0_busy, 1);
    chk({nm, "_busy_at_done"}, fd_busy, 0);
    wq.delete();
  endtask

  task automatic load_text(input string s);
    for (int i = 0; i < 16; i++) mem[i] = s[i];
  endtask

  task automatic load_rand();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int base;
    int rd0;
    int n;
    rst = 1'b1;
    en  = 1'b0;
    load_text("HELLO WORLD 1234");
    repeat (3) @(negedge clk);
    chk("rst_wr_n", int'(wr_n), 4'hF);
    chk("rst_data", int'(ddata), 0);
    chk("rst_addr", int'(daddr), 0);
    chk("rst_rden", int'(rden), 0);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fd", int'(fd), 0);
    chk("rst_caret", int'(caret), 1);
    rst = 1'b0;
    en  = 1'b1;
    run_frame("hello");

    load_text("HELLO WORLD 1234");
    mem[3] = 8'h61;
    mem[7] = 8'hC1;
    run_frame("filter");

    load_rand();
    run_frame("rand1");
    load_rand();
    run_frame("rand2");

    // Enable dropped during the WR pulse of character 5
    load_rand();
    wq.delete();
    base = fd_cnt;
    rd0  = rd_cnt;
    n    = 0;
    while (!(wq.size() == 5 && in_low) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drop_reach_idx5", int'(wq.size() == 5 && in_low), 1);
    #1 en = 1'b0;
    repeat (40) @(posedge clk);
    chk("drop_nwr", wq.size(), 6);
    if (wq.size() == 6) begin
      chk("drop_chip5", wq[5].chip, 1);
      chk("drop_addr5", wq[5].addr, 2);
      chk("drop_data5", wq[5].data, exp_char(mem[5]));
      chk("drop_wrlen5", wq[5].len, 4);
    end
    chk("drop_reads", rd_cnt - rd0, 6);
    chk("drop_no_fd", fd_cnt - base, 0);
    chk("drop_busy_fall", busy_fall - rise_scnt, 2);
    @(negedge clk);
    chk("drop_busy_idle", int'(busy), 0);

    // Reset asserted in the middle of a WR pulse
    en = 1'b1;
    n  = 0;
    while (!in_low && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("rst_reach_pulse", int'(in_low), 1);
    #1 rst = 1'b1;
    #1;
    chk("rstp_wr_n", int'(wr_n), 4'hF);
    chk("rstp_busy", int'(busy), 0);
    chk("rstp_data", int'(ddata), 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame("after_rst");

    chk("caret_fall1", edge_c[0], 10);
    chk("caret_rise", edge_c[1], 20);
    chk("caret_fall2", edge_c[2], 30);
    chk("wr_onehot", bad_wr, 0);
    chk("read_outside_busy", rd_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
